// File: rtl/satatx_framearb.sv
// rtl/satatx_framearb.sv - two-source SATA TX frame arbiter feeding the CRC generator stream
// Optional feature macro: SATA_ARB_RR_EN (round-robin tie-break; fixed S0 priority when undefined)
module satatx_framearb #(
    parameter int GAP_CYCLES = 4,
    parameter int LGMAXLEN   = 12,
    parameter int MAX_DWORDS = 2049
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        S0_AXIS_TVALID,
    output logic        S0_AXIS_TREADY,
    input  logic [31:0] S0_AXIS_TDATA,
    input  logic        S0_AXIS_TLAST,
    input  logic        S1_AXIS_TVALID,
    output logic        S1_AXIS_TREADY,
    input  logic [31:0] S1_AXIS_TDATA,
    input  logic        S1_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    input  logic        i_hold,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_overlength
);

    // Gap counter runs 0..GAP_CYCLES-1; keep at least one bit so GAP_CYCLES of 0 or 1 still elaborates.
    localparam int                  GW          = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]       LP_GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [LGMAXLEN-1:0] LP_OVL_AT   = LGMAXLEN'(MAX_DWORDS);
    localparam logic [LGMAXLEN-1:0] LP_CNT_SAT  = {LGMAXLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_FLUSH = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_grant;
    logic [1:0]          w_grant_next;
    logic                w_grant_load;
    logic                w_pick_s1;

    logic                r_m_tvalid;
    logic [31:0]         r_m_tdata;
    logic                r_m_tlast;

    logic [LGMAXLEN-1:0] r_beats;
    logic                r_overlength;
    logic [GW-1:0]       r_gap_cnt;

    logic                w_m_free;
    logic                w_s0_ready;
    logic                w_s1_ready;
    logic                w_accept;
    logic [31:0]         w_in_data;
    logic                w_in_last;
    logic                w_out_last_hs;
    logic                w_gap_done;

    // The output register can take a new beat when empty or when its current beat is leaving.
    assign w_m_free      = !r_m_tvalid || M_AXIS_TREADY;
    assign w_s0_ready    = (r_state == S_FRAME) && r_grant[0] && w_m_free;
    assign w_s1_ready    = (r_state == S_FRAME) && r_grant[1] && w_m_free;
    assign w_accept      = (w_s0_ready && S0_AXIS_TVALID) || (w_s1_ready && S1_AXIS_TVALID);
    assign w_in_data     = r_grant[1] ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    assign w_in_last     = r_grant[1] ? S1_AXIS_TLAST : S0_AXIS_TLAST;
    assign w_out_last_hs = r_m_tvalid && M_AXIS_TREADY && r_m_tlast;
    assign w_gap_done    = (r_gap_cnt == LP_GAP_LAST);

`ifdef SATA_ARB_RR_EN
    logic r_last_s1;

    // On a tie, hand the link to whichever source did not win the previous grant.
    assign w_pick_s1 = S1_AXIS_TVALID && (!S0_AXIS_TVALID || !r_last_s1);

    // Remember the last winner; starting at S1 lets S0 take the first tie after reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_last_s1 <= 1'b1;
        end else if (w_grant_load) begin
            r_last_s1 <= w_pick_s1;
        end
    end
`else
    // Fixed priority: S1 only wins when S0 has nothing to send.
    assign w_pick_s1 = S1_AXIS_TVALID && !S0_AXIS_TVALID;
`endif

    // Frame sequencing: arbitrate, pass one whole frame, drain it, then hold the idle gap.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_grant_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_hold && (S0_AXIS_TVALID || S1_AXIS_TVALID)) begin
                    w_state_next = S_FRAME;
                    w_grant_load = 1'b1;
                    w_grant_next = w_pick_s1 ? 2'b10 : 2'b01;
                end
            end
            S_FRAME: begin
                if (w_accept && w_in_last) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_out_last_hs) begin
                    w_grant_next = 2'b00;
                    w_state_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = 2'b00;
            end
        endcase
    end

    // State and owner registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    // Idle-gap timer: held at zero outside the gap, stops at its last value until the state leaves.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_gap_cnt <= '0;
        end else if (r_state != S_GAP) begin
            r_gap_cnt <= '0;
        end else if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Output stage: load on accept, hold while stalled, otherwise empty with data zeroed.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 32'd0;
            r_m_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_in_data;
            r_m_tlast  <= w_in_last;
        end else if (w_m_free) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 32'd0;
            r_m_tlast  <= 1'b0;
        end
    end

    // Beat counter per frame; saturates so very long frames cannot wrap back under the limit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_beats <= '0;
        end else if (w_grant_load) begin
            r_beats <= '0;
        end else if (w_accept && (r_beats != LP_CNT_SAT)) begin
            r_beats <= r_beats + 1'b1;
        end
    end

    // Single pulse when the beat that crosses the length limit is accepted; the frame itself is untouched.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_overlength <= 1'b0;
        end else begin
            r_overlength <= w_accept && (r_beats == LP_OVL_AT) && (r_beats != LP_CNT_SAT);
        end
    end

    assign S0_AXIS_TREADY = w_s0_ready;
    assign S1_AXIS_TREADY = w_s1_ready;
    assign M_AXIS_TVALID  = r_m_tvalid;
    assign M_AXIS_TDATA   = r_m_tdata;
    assign M_AXIS_TLAST   = r_m_tlast;
    assign o_grant        = r_grant;
    assign o_busy         = (r_state != S_IDLE);
    assign o_overlength   = r_overlength;

endmodule

// File: tb/tb_satatx_framearb.sv
// tb/tb_satatx_framearb.sv - directed self-checking bench for satatx_framearb
module tb_satatx_framearb;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        s0_tvalid = 1'b0;
    logic        s0_tready;
    logic [31:0] s0_tdata  = 32'd0;
    logic        s0_tlast  = 1'b0;
    logic        s1_tvalid = 1'b0;
    logic        s1_tready;
    logic [31:0] s1_tdata  = 32'd0;
    logic        s1_tlast  = 1'b0;
    logic        m_tvalid;
    logic        m_tready  = 1'b1;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        hold      = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic        ovl;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          tmo   = 0;
    logic        abort = 1'b0;

    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int          tl_cyc[$];
    int          rise_cyc[$];
    int          ovl_cnt    = 0;
    int          ovl_idx    = -1;
    int          viol       = 0;
    logic [1:0]  prev_grant = 2'b00;

    int          obs_base;
    int          tl_base;
    int          rise_base;
    int          ovl_base;

    satatx_framearb dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .S0_AXIS_TVALID (s0_tvalid),
        .S0_AXIS_TREADY (s0_tready),
        .S0_AXIS_TDATA  (s0_tdata),
        .S0_AXIS_TLAST  (s0_tlast),
        .S1_AXIS_TVALID (s1_tvalid),
        .S1_AXIS_TREADY (s1_tready),
        .S1_AXIS_TDATA  (s1_tdata),
        .S1_AXIS_TLAST  (s1_tlast),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TLAST   (m_tlast),
        .i_hold         (hold),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_overlength   (ovl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Negedge monitor: output beats about to hand off, TLAST hand-off cycles, grant rises, pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovl) begin
                ovl_cnt <= ovl_cnt + 1;
                ovl_idx <= obs_q.size();
            end
            if (m_tvalid && m_tready) begin
                obs_q.push_back({m_tlast, m_tdata});
                if (m_tlast) tl_cyc.push_back(cyc + 1);
            end
            if (grant != 2'b00 && prev_grant == 2'b00) rise_cyc.push_back(cyc);
            if ((s0_tready && grant != 2'b01) || (s1_tready && grant != 2'b10)) viol <= viol + 1;
        end
        prev_grant <= grant;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        obs_base  = obs_q.size();
        tl_base   = tl_cyc.size();
        rise_base = rise_cyc.size();
        ovl_base  = ovl_cnt;
        exp_q.delete();
    endtask

    task automatic add_exp(input logic [31:0] base, input int n);
        logic l;
        for (int i = 0; i < n; i++) begin
            l = (i == n - 1);
            exp_q.push_back({l, base + 32'(i)});
        end
    endtask

    task automatic cmp_frames(input string tag);
        int errs;
        errs = 0;
        chk({tag, "_count"}, 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (obs_base + i) < obs_q.size(); i++)
            if (obs_q[obs_base + i] !== exp_q[i]) errs++;
        chk({tag, "_beats"}, 32'(errs), 32'd0);
    endtask

    task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
        if (src == 0) begin
            s0_tvalid = v; s0_tdata = d; s0_tlast = l;
        end else begin
            s1_tvalid = v; s1_tdata = d; s1_tlast = l;
        end
    endtask

    task automatic send(input int src, input int n, input logic [31:0] base);
        int   waitc;
        logic got;
        logic quit;
        quit = 1'b0;
        for (int i = 0; i < n && !quit; i++) begin
            drive(src, 1'b1, base + 32'(i), (i == n - 1));
            got   = 1'b0;
            waitc = 0;
            while (!got && !quit) begin
                @(negedge clk);
                if (abort) quit = 1'b1;
                else if ((src == 0) ? s0_tready : s1_tready) got = 1'b1;
                else begin
                    waitc++;
                    if (waitc > 6000) begin
                        tmo++;
                        quit = 1'b1;
                    end
                end
            end
            if (got) begin
                @(posedge clk);
                #1;
            end
        end
        drive(src, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (busy) tmo++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          start;
        int          w;
        logic [31:0] held;
        int          unstable;
        int          rdy_bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overlength", 32'(ovl), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First tie after reset: S0 frame goes first in either arbitration mode
        mark();
        add_exp(32'h100, 2);
        add_exp(32'h200, 2);
        fork
            send(0, 2, 32'h100);
            send(1, 2, 32'h200);
        join
        wait_idle();
        cmp_frames("tie_reset");

        // S0 3-beat frame A0..A2, then a single-beat frame: 1-cycle grant, 4-cycle gap plus 1 idle
        mark();
        add_exp(32'hA0, 3);
        add_exp(32'hB0, 1);
        start = cyc;
        send(0, 3, 32'hA0);
        send(0, 1, 32'hB0);
        wait_idle();
        cmp_frames("s0_frame");
        chk("s0_grant_rises", 32'(rise_cyc.size() - rise_base), 32'd2);
        if (rise_cyc.size() >= rise_base + 2 && tl_cyc.size() > tl_base) begin
            chk("grant_latency", 32'(rise_cyc[rise_base] - start), 32'd1);
            chk("gap_to_next_grant", 32'(rise_cyc[rise_base + 1] - tl_cyc[tl_base]), 32'd5);
        end

        // Repeated tie with S0 as the last winner
        mark();
`ifdef SATA_ARB_RR_EN
        add_exp(32'h320, 2);
        add_exp(32'h310, 2);
`else
        add_exp(32'h310, 2);
        add_exp(32'h320, 2);
`endif
        fork
            send(0, 2, 32'h310);
            send(1, 2, 32'h320);
        join
        wait_idle();
        cmp_frames("tie_repeat");

        // Downstream stall of 5 cycles mid-frame; i_hold raised mid-frame must not disturb it
        mark();
        add_exp(32'h400, 6);
        held     = 32'd0;
        unstable = 0;
        rdy_bad  = 0;
        fork
            send(1, 6, 32'h400);
            begin
                w = 0;
                while (obs_q.size() < obs_base + 2 && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                m_tready = 1'b0;
                hold     = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) held = m_tdata;
                    if (!m_tvalid || m_tdata !== held) unstable++;
                    if (s1_tready) rdy_bad++;
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        wait_idle();
        hold = 1'b0;
        chk("stall_held_data", held, 32'h402);
        chk("stall_unstable", 32'(unstable), 32'd0);
        chk("stall_src_ready", 32'(rdy_bad), 32'd0);
        cmp_frames("stall");

        // i_hold blocks a new grant; release grants on the next clock; single-beat frame
        mark();
        add_exp(32'h700, 1);
        hold = 1'b1;
        drive(0, 1'b1, 32'h700, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold_grant", 32'(grant), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_release_grant", 32'(grant), 32'd1);
        send(0, 1, 32'h700);
        wait_idle();
        cmp_frames("hold_frame");

        // Exactly MAX_DWORDS beats: no overlength pulse
        mark();
        add_exp(32'h10000, 2049);
        send(1, 2049, 32'h10000);
        wait_idle();
        cmp_frames("len2049");
        chk("len2049_ovl_pulses", 32'(ovl_cnt - ovl_base), 32'd0);

        // MAX_DWORDS+1 beats: one pulse, visible while beat 2050 sits on the output
        mark();
        add_exp(32'h20000, 2050);
        send(1, 2050, 32'h20000);
        wait_idle();
        cmp_frames("len2050");
        chk("len2050_ovl_pulses", 32'(ovl_cnt - ovl_base), 32'd1);
        chk("len2050_ovl_pos", 32'(ovl_idx - obs_base), 32'd2049);

        // Reset asserted mid-frame, then a clean frame afterwards
        mark();
        fork
            send(0, 6, 32'h500);
            begin
                w = 0;
                while (obs_q.size() < obs_base + 3 && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
                chk("midrst_grant", 32'(grant), 32'd0);
                chk("midrst_busy", 32'(busy), 32'd0);
                chk("midrst_m_tdata", m_tdata, 32'd0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        @(posedge clk);
        #1;
        mark();
        add_exp(32'h600, 2);
        start = cyc;
        send(1, 2, 32'h600);
        wait_idle();
        cmp_frames("post_reset");
        chk("post_reset_rises", 32'(rise_cyc.size() - rise_base), 32'd1);
        if (rise_cyc.size() > rise_base)
            chk("post_reset_latency", 32'(rise_cyc[rise_base] - start), 32'd1);

        chk("tready_vs_grant", 32'(viol), 32'd0);
        chk("timeouts", 32'(tmo), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
